pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter n, default 32, giving the address/PC width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 0, giving the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-005 The block SHALL have port stall, input, 1 bit: hold the current instruction in EXEC.
REQ-006 The block SHALL have port branch_taken, input, 1 bit: take branch_target this instruction.
REQ-007 The block SHALL have port branch_target, input, n bits: branch destination.
REQ-008 The block SHALL have port jump, input, 1 bit: take jump_target this instruction.
REQ-009 The block SHALL have port jump_target, input, n bits: jump destination.
REQ-010 The block SHALL have port halt, input, 1 bit: stop fetching after the current instruction.
REQ-011 The block SHALL have port imem_ready, input, 1 bit: instruction memory returns data this cycle.
REQ-012 The block SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-013 The block SHALL have port imem_addr, output, n bits: fetch address; equals pc.
REQ-014 The block SHALL have port pc, output, n bits: registered current program counter.
REQ-015 The block SHALL have port pc_plus4, output, n bits: pc + 4, combinational.
REQ-016 The block SHALL have port instr_valid, output, 1 bit: the fetched instruction is executing this cycle.
REQ-017 The block SHALL have port halted, output, 1 bit: the block is in HALT.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, EXEC and HALT, encoded in registers.
REQ-019 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-020 FETCH SHALL drive imem_req=1 and stay in FETCH while imem_ready=0.
REQ-021 FETCH with imem_ready=1 SHALL go to EXEC on the next edge.
REQ-022 EXEC SHALL drive instr_valid=1 and imem_req=0.
REQ-023 EXEC with stall=1 SHALL remain in EXEC, holding pc, and SHALL ignore branch_taken, jump and halt.
REQ-024 EXEC with stall=0 SHALL update pc by priority: halt, then jump, then branch_taken, then sequential.
REQ-025 On halt, the next state SHALL be HALT and pc SHALL become pc_plus4.
REQ-026 Otherwise the next state SHALL be FETCH, with pc set to jump_target, branch_target or pc_plus4 according to that priority.
REQ-027 Any loaded target SHALL have bits [1:0] forced to 0, keeping pc word-aligned.
REQ-028 pc_plus4 SHALL be computed modulo 2^n, so pc = 2^n-4 wraps to 0 with no flag.
REQ-029 HALT SHALL be absorbing: imem_req=0, instr_valid=0, halted=1, pc held; only reset exits it.
REQ-030 imem_ready SHALL be ignored in every state other than FETCH.
REQ-031 imem_addr SHALL equal pc in every state.

Reset
REQ-032 While rst_n=0, the block SHALL asynchronously force: state=IDLE, pc=RESET_VECTOR, imem_req=0, instr_valid=0, halted=0.
REQ-033 Reset asserted mid-FETCH or mid-EXEC SHALL abort the operation immediately, with no pc update.
REQ-034 After rst_n rises, the first imem_req SHALL appear on the second rising edge (IDLE then FETCH).

Verification
REQ-035 Test: reset, then imem_ready=1 constantly, no control inputs -> pc sequence 0,4,8,... with one EXEC every 2 cycles.
REQ-036 Test: imem_ready held low 3 cycles in FETCH -> imem_req=1 and pc=0 for 3 cycles, then EXEC.
REQ-037 Test: in EXEC assert jump=1 with jump_target=0x100 and branch_taken=1 with branch_target=0x200 -> next pc=0x100.
REQ-038 Test: branch_target=0x203 -> pc=0x200; pc=0xFFFFFFFC sequential -> pc=0.
REQ-039 Test: stall=1 for 2 EXEC cycles with branch_taken=1 -> pc unchanged and instr_valid=1 for 3 cycles total; branch taken when stall drops.
REQ-040 Test: halt=1 in EXEC at pc=0x10 -> halted=1, pc=0x14 thereafter; rst_n pulse mid-FETCH -> pc=RESET_VECTOR immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE -> FETCH -> EXEC loop with stall, jump/branch
// redirection and an absorbing HALT state. Only an asynchronous reset leaves HALT.
module pc_sequencer #(
  parameter int             n            = 32,
  parameter logic [n-1:0]   RESET_VECTOR = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [n-1:0] branch_target,
  input  logic         jump,
  input  logic [n-1:0] jump_target,
  input  logic         halt,
  input  logic         imem_ready,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  output logic [n-1:0] pc,
  output logic [n-1:0] pc_plus4,
  output logic         instr_valid,
  output logic         halted,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Loaded targets are forced word-aligned by clearing bits [1:0].
  localparam logic [n-1:0] ALIGN_MASK = {{(n-2){1'b1}}, 2'b00};
  localparam logic [n-1:0] FOUR       = {{(n-3){1'b0}}, 3'b100};

  state_t       state, state_nxt;
  logic [n-1:0] pc_nxt;
  logic         armed;

  // armed stays low for the first edge after reset release, so IDLE occupies
  // one full clock before FETCH no matter where in the cycle rst_n rose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_VECTOR;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      armed <= 1'b1;
    end
  end

  assign pc_plus4  = pc + FOUR;
  assign imem_addr = pc;
  assign state_dbg = state;

  // Fetch handshake: imem_req stays high for every FETCH cycle and the
  // instruction is accepted on the first rising edge that also sees imem_ready=1;
  // imem_ready has no effect in any other state.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      IDLE: begin
        if (armed) state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_nxt = EXEC;
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          if (halt) begin
            state_nxt = HALT;
            pc_nxt    = pc_plus4;
          end else if (jump) begin
            state_nxt = FETCH;
            pc_nxt    = jump_target & ALIGN_MASK;
          end else if (branch_taken) begin
            state_nxt = FETCH;
            pc_nxt    = branch_target & ALIGN_MASK;
          end else begin
            state_nxt = FETCH;
            pc_nxt    = pc_plus4;
          end
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected fetch addresses are queued when the
// steering inputs are driven and compared when the instruction reaches EXEC.
module tb_pc_sequencer;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        halt;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        halted;
  logic [1:0]  state_dbg;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          w;

  pc_sequencer #(.n(32), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .halt(halt),
    .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
    .halted(halted), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for EXEC; pops the queued address and checks pc against it.
  task automatic wait_exec(output int waited);
    logic [31:0] e;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!instr_valid && waited < 8);
    if (!instr_valid) begin
      checks++;
      errors++;
      $error("FAIL exec_timeout observed=%0d expected=instr_valid", waited);
    end else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL exec_unexpected observed=%0h expected=empty_queue", pc);
    end else begin
      e = exp_q.pop_front();
      check("exec_pc", pc, e);
      check("exec_addr", imem_addr, e);
      check("exec_req", 32'(imem_req), 32'd0);
    end
  endtask

  // Drive steering inputs for one EXEC cycle, queue the expected next pc,
  // then confirm the next instruction executes two cycles after this one.
  task automatic step(input logic j, input logic [31:0] jt, input logic b,
                      input logic [31:0] bt, input logic [31:0] next_pc);
    int lat;
    jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
    @(negedge clk);
    jump = 1'b0; branch_taken = 1'b0;
    exp_q.push_back(next_pc);
    wait_exec(lat);
    check("exec_spacing", 32'(lat), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; halt = 1'b0; imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));

    // IDLE for one cycle, then FETCH waiting 3 cycles on imem_ready
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req", 32'(imem_req), 32'd0);
    check("idle_state", 32'(state_dbg), 32'(S_IDLE));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fetch_req", 32'(imem_req), 32'd1);
      check("fetch_pc", pc, 32'h0);
    end
    imem_ready = 1'b1;
    exp_q.push_back(32'h0);
    wait_exec(w);
    check("first_exec_lat", 32'(w), 32'd1);
    check("pc_plus4", pc_plus4, 32'h4);

    // Sequential, then priority and alignment cases
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h8);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'hC);
    step(1'b1, 32'h100, 1'b1, 32'h200, 32'h100);
    step(1'b0, 32'h0, 1'b1, 32'h203, 32'h200);
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Stall for two extra EXEC cycles; branch and halt ignored meanwhile
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40; halt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_pc", pc, 32'h0);
    end
    stall = 1'b0; halt = 1'b0;
    @(negedge clk);
    branch_taken = 1'b0;
    check("post_stall_req", 32'(imem_req), 32'd1);
    check("post_stall_pc", pc, 32'h40);
    exp_q.push_back(32'h40);
    wait_exec(w);

    // Halt at 0x10 and confirm HALT ignores everything
    step(1'b1, 32'h10, 1'b0, 32'h0, 32'h10);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    jump = 1'b1; jump_target = 32'h300; imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_pc", pc, 32'h14);
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_valid", 32'(instr_valid), 32'd0);
      check("halt_state", 32'(state_dbg), 32'(S_HALT));
      @(negedge clk);
    end
    jump = 1'b0;

    // Reset leaves HALT; then reset again mid-FETCH at a non-reset pc
    rst_n = 1'b0;
    #1;
    check("halt_rst_pc", pc, 32'h0);
    check("halt_rst_flag", 32'(halted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    wait_exec(w);
    check("restart_lat", 32'(w), 32'd3);
    jump = 1'b1; jump_target = 32'h80; imem_ready = 1'b0;
    @(negedge clk);
    jump = 1'b0;
    check("midfetch_pc", pc, 32'h80);
    check("midfetch_state", 32'(state_dbg), 32'(S_FETCH));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_req", 32'(imem_req), 32'd0);
    check("async_rst_state", 32'(state_dbg), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
